// File: rtl/slot_buffer.sv
// Slot-allocated holding buffer with fixed-priority pop pick. Writes and pops land at the next clk edge; outputs are combinational from state.
// Backpressure: wr_ready drops when every slot is live, and writes made then are dropped; rd_en is ignored while empty.
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif

module slot_buffer #(
   parameter int DATA = 32,
   parameter int IN   = 4,
   parameter bit MSB  = `Enable
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      wr_en,
   input  logic [DATA-1:0]           wr_data,
   output logic                      wr_ready,
   input  logic                      rd_en,
   output logic                      rd_valid,
   output logic [IN-1:0]             rd_pos,
   output logic [DATA-1:0]           rd_data,
   output logic [IN-1:0]             entry_valid,
   output logic [DATA*IN-1:0]        entry_data,
   output logic [$clog2(IN+1)-1:0]   count
);

   localparam int CW = $clog2(IN+1);

   logic [IN-1:0]   valid_q;
   logic [IN-1:0]   valid_d;
   logic [DATA-1:0] data_q [IN];
   logic [CW-1:0]   count_q;
   logic [CW-1:0]   count_d;
   logic [IN-1:0]   wr_slot;
   logic [IN-1:0]   pick;
   logic [DATA-1:0] rd_mux;
   logic            wr_acc;
   logic            rd_acc;

   // Free-slot search looks only at the registered bitmap, so a slot being
   // popped this cycle is not yet eligible for the concurrent write.
   always_comb begin
      wr_slot = '0;
      for (int i = IN - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            wr_slot    = '0;
            wr_slot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      pick = '0;
      if (MSB) begin
         for (int i = 0; i < IN; i++) begin
            if (valid_q[i]) begin
               pick    = '0;
               pick[i] = 1'b1;
            end
         end
      end else begin
         for (int i = IN - 1; i >= 0; i--) begin
            if (valid_q[i]) begin
               pick    = '0;
               pick[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < IN; i++) begin
         rd_mux = rd_mux | (data_q[i] & {DATA{pick[i]}});
      end
   end

   assign wr_ready    = ~(&valid_q);
   assign rd_valid    = |valid_q;
   assign rd_pos      = pick;
   assign rd_data     = rd_mux;
   assign entry_valid = valid_q;
   assign count       = count_q;

   assign wr_acc = wr_en & wr_ready & ~flush;
   assign rd_acc = rd_en & rd_valid & ~flush;

   for (genvar g = 0; g < IN; g++) begin : g_edata
      assign entry_data[DATA*g +: DATA] = data_q[g];
   end

   always_comb begin
      valid_d = valid_q;
      count_d = count_q;
      if (flush) begin
         valid_d = '0;
         count_d = '0;
      end else begin
         if (rd_acc) valid_d = valid_d & ~pick;
         if (wr_acc) valid_d = valid_d | wr_slot;
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Popping only clears the valid bit; slot data persists until overwritten.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         count_q <= '0;
         for (int i = 0; i < IN; i++) data_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         if (wr_acc) begin
            for (int i = 0; i < IN; i++) begin
               if (wr_slot[i]) data_q[i] <= wr_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_slot_buffer.sv
// Directed bench for slot_buffer: one instance per pop priority, shared stimulus.
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif

module tb_slot_buffer;

   logic         clk;
   logic         reset;
   logic         flush;
   logic         wr_en;
   logic [31:0]  wr_data;
   logic         rd_en;

   logic         a_wr_ready, a_rd_valid;
   logic [3:0]   a_rd_pos, a_entry_valid;
   logic [31:0]  a_rd_data;
   logic [127:0] a_entry_data;
   logic [2:0]   a_count;

   logic         b_wr_ready, b_rd_valid;
   logic [3:0]   b_rd_pos, b_entry_valid;
   logic [31:0]  b_rd_data;
   logic [127:0] b_entry_data;
   logic [2:0]   b_count;

   int n_vec = 0;
   int n_mis = 0;

   slot_buffer #(.DATA(32), .IN(4), .MSB(`Enable)) dut_a (
      .clk(clk), .reset(reset), .flush(flush),
      .wr_en(wr_en), .wr_data(wr_data), .wr_ready(a_wr_ready),
      .rd_en(rd_en), .rd_valid(a_rd_valid), .rd_pos(a_rd_pos), .rd_data(a_rd_data),
      .entry_valid(a_entry_valid), .entry_data(a_entry_data), .count(a_count)
   );

   slot_buffer #(.DATA(32), .IN(4), .MSB(`Disable)) dut_b (
      .clk(clk), .reset(reset), .flush(flush),
      .wr_en(wr_en), .wr_data(wr_data), .wr_ready(b_wr_ready),
      .rd_en(rd_en), .rd_valid(b_rd_valid), .rd_pos(b_rd_pos), .rd_data(b_rd_data),
      .entry_valid(b_entry_valid), .entry_data(b_entry_data), .count(b_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic         rst;
      logic         fl;
      logic         we;
      logic [31:0]  wd;
      logic         re;
      logic [3:0]   ev;
      logic [2:0]   cnt;
      logic         wrdy;
      logic         rv;
      logic [3:0]   pos;
      logic [31:0]  rdat;
      logic [127:0] ed;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the edge; count must
   // always equal the population of the exported bitmap.
   task automatic apply(input logic rst, input logic fl, input logic we,
                        input logic [31:0] wd, input logic re);
      @(negedge clk);
      reset   = rst;
      flush   = fl;
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      @(posedge clk);
      #1;
      chk("popcount_a", 128'(a_count), 128'($countones(a_entry_valid)));
      chk("popcount_b", 128'(b_count), 128'($countones(b_entry_valid)));
   endtask

   initial begin
      reset = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;

      //          rst   fl    we    wd     re    ev       cnt  wrdy  rv    pos      rdat   entry_data {s3,s2,s1,s0}
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, 4'b0000, 32'd0,  {32'd0, 32'd0, 32'd0, 32'd0}};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, 4'b0000, 32'd0,  {32'd0, 32'd0, 32'd0, 32'd0}};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 4'b0001, 3'd1, 1'b1, 1'b1, 4'b0001, 32'd1,  {32'd0, 32'd0, 32'd0, 32'd1}};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'd2, 1'b0, 4'b0011, 3'd2, 1'b1, 1'b1, 4'b0010, 32'd2,  {32'd0, 32'd0, 32'd2, 32'd1}};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'd3, 1'b0, 4'b0111, 3'd3, 1'b1, 1'b1, 4'b0100, 32'd3,  {32'd0, 32'd3, 32'd2, 32'd1}};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'd4, 1'b0, 4'b1111, 3'd4, 1'b0, 1'b1, 4'b1000, 32'd4,  {32'd4, 32'd3, 32'd2, 32'd1}};
      // write while full is dropped
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 4'b1111, 3'd4, 1'b0, 1'b1, 4'b1000, 32'd4,  {32'd4, 32'd3, 32'd2, 32'd1}};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'b0111, 3'd3, 1'b1, 1'b1, 4'b0100, 32'd3,  {32'd4, 32'd3, 32'd2, 32'd1}};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'd5, 1'b0, 4'b1111, 3'd4, 1'b0, 1'b1, 4'b1000, 32'd5,  {32'd5, 32'd3, 32'd2, 32'd1}};
      // full write+pop: pop only
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'd6, 1'b1, 4'b0111, 3'd3, 1'b1, 1'b1, 4'b0100, 32'd3,  {32'd5, 32'd3, 32'd2, 32'd1}};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'b0011, 3'd2, 1'b1, 1'b1, 4'b0010, 32'd2,  {32'd5, 32'd3, 32'd2, 32'd1}};
      // pop slot1 while writing 9 into slot2
      tbl[11] = '{1'b0, 1'b0, 1'b1, 32'd9, 1'b1, 4'b0101, 3'd2, 1'b1, 1'b1, 4'b0100, 32'd9,  {32'd5, 32'd9, 32'd2, 32'd1}};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 32'd10, 1'b0, 4'b0111, 3'd3, 1'b1, 1'b1, 4'b0100, 32'd9, {32'd5, 32'd9, 32'd10, 32'd1}};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 32'd11, 1'b0, 4'b1111, 3'd4, 1'b0, 1'b1, 4'b1000, 32'd11, {32'd11, 32'd9, 32'd10, 32'd1}};
      // flush beats write and pop; data untouched
      tbl[14] = '{1'b0, 1'b1, 1'b1, 32'd7, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b0, 4'b0000, 32'd0,  {32'd11, 32'd9, 32'd10, 32'd1}};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 32'd12, 1'b0, 4'b0001, 3'd1, 1'b1, 1'b1, 4'b0001, 32'd12, {32'd11, 32'd9, 32'd10, 32'd12}};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 32'd13, 1'b0, 4'b0011, 3'd2, 1'b1, 1'b1, 4'b0010, 32'd13, {32'd11, 32'd9, 32'd13, 32'd12}};
      // reset mid-fill, with a write pending
      tbl[17] = '{1'b1, 1'b0, 1'b1, 32'd14, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, 4'b0000, 32'd0, {32'd0, 32'd0, 32'd0, 32'd0}};
      // pop on empty changes nothing
      tbl[18] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b0, 4'b0000, 32'd0,  {32'd0, 32'd0, 32'd0, 32'd0}};

      for (int i = 0; i < 19; i++) begin
         apply(tbl[i].rst, tbl[i].fl, tbl[i].we, tbl[i].wd, tbl[i].re);
         chk($sformatf("v%0d entry_valid", i), 128'(a_entry_valid), 128'(tbl[i].ev));
         chk($sformatf("v%0d count", i),       128'(a_count),       128'(tbl[i].cnt));
         chk($sformatf("v%0d wr_ready", i),    128'(a_wr_ready),    128'(tbl[i].wrdy));
         chk($sformatf("v%0d rd_valid", i),    128'(a_rd_valid),    128'(tbl[i].rv));
         chk($sformatf("v%0d rd_pos", i),      128'(a_rd_pos),      128'(tbl[i].pos));
         chk($sformatf("v%0d rd_data", i),     128'(a_rd_data),     128'(tbl[i].rdat));
         chk($sformatf("v%0d entry_data", i),  a_entry_data,        tbl[i].ed);
      end

      // Lowest-first pick: write 1,2,3 then pop three times
      apply(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      apply(1'b0, 1'b0, 1'b1, 32'd1, 1'b0);
      apply(1'b0, 1'b0, 1'b1, 32'd2, 1'b0);
      apply(1'b0, 1'b0, 1'b1, 32'd3, 1'b0);
      chk("lsb entry_valid", 128'(b_entry_valid), 128'(4'b0111));
      chk("lsb rd_pos0", 128'(b_rd_pos), 128'(4'b0001));
      chk("lsb rd_data0", 128'(b_rd_data), 128'(32'd1));
      apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("lsb rd_data1", 128'(b_rd_data), 128'(32'd2));
      chk("lsb count1", 128'(b_count), 128'(3'd2));
      apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("lsb rd_data2", 128'(b_rd_data), 128'(32'd3));
      chk("lsb rd_pos2", 128'(b_rd_pos), 128'(4'b0100));
      apply(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("lsb rd_valid3", 128'(b_rd_valid), 128'(1'b0));
      chk("lsb count3", 128'(b_count), 128'(3'd0));
      chk("lsb rd_data3", 128'(b_rd_data), 128'(32'd0));
      // popped slots keep their data
      chk("lsb entry_data", b_entry_data, {32'd0, 32'd3, 32'd2, 32'd1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
